// File: rtl/ccx_misr_compactor.sv
// Windowed MISR compactor for one CCX crossbar lane: folds WINDOW enabled cycles
// of lane data into a DATA_W-bit signature and strobes misr_reset at window start.
module ccx_misr_compactor #(
  parameter int                DATA_W = 101,
  parameter logic [DATA_W-1:0] POLY   = 101'h15,
  parameter int                WINDOW = 124
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              start,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              misr_reset,
  output logic [DATA_W-1:0] sig,
  output logic              sig_vld,
  output logic              busy
);

  localparam int CNT_W = (WINDOW < 1) ? 1 : $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  sig_q;
  logic [DATA_W-1:0]  sig_d;
  logic               misr_reset_q;
  logic               sig_vld_q;
  logic               busy_q;

  // One MISR step: shift left, fold POLY on MSB carry-out, XOR in the lane word.
  function automatic logic [DATA_W-1:0] misr_step(
    input logic [DATA_W-1:0] cur,
    input logic              vld,
    input logic [DATA_W-1:0] data
  );
    logic [DATA_W-1:0] nxt;
    nxt = {cur[DATA_W-2:0], 1'b0};
    if (cur[DATA_W-1]) begin
      nxt = nxt ^ POLY;
    end else begin
      nxt = nxt;
    end
    if (vld) begin
      nxt = nxt ^ data;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  // Candidate signature for the current RUN cycle.
  always_comb begin
    sig_d = misr_step(sig_q, in_vld, in_data);
  end

  // Window FSM; the strobe/status outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sig_q        <= '0;
      misr_reset_q <= 1'b0;
      sig_vld_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_RESET;
            misr_reset_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_RESET: begin
          state_q      <= S_RUN;
          sig_q        <= '0;
          cnt_q        <= '0;
          misr_reset_q <= 1'b0;
          busy_q       <= 1'b1;
        end
        S_RUN: begin
          if (ena) begin
            sig_q <= sig_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WINDOW - 1)) begin
              state_q   <= S_DONE;
              busy_q    <= 1'b0;
              sig_vld_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state_q      <= S_RESET;
            sig_vld_q    <= 1'b0;
            misr_reset_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          cnt_q        <= '0;
          sig_q        <= '0;
          misr_reset_q <= 1'b0;
          sig_vld_q    <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign misr_reset = misr_reset_q;
  assign sig        = sig_q;
  assign sig_vld    = sig_vld_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ccx_misr_compactor.sv
// Directed bench for ccx_misr_compactor: small 8-bit instance for function,
// plus a full-size instance for the misr_reset to sig_vld spacing.
module tb_ccx_misr_compactor;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        start;
  logic        in_vld;
  logic [7:0]  in_data;
  logic        misr_reset;
  logic [7:0]  sig;
  logic        sig_vld;
  logic        busy;

  logic          big_start;
  logic [100:0]  big_data;
  logic          big_misr_reset;
  logic [100:0]  big_sig;
  logic          big_sig_vld;
  logic          big_busy;

  int n_chk;
  int n_pass;

  ccx_misr_compactor #(.DATA_W(8), .POLY(8'h1D), .WINDOW(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .in_vld(in_vld),
    .in_data(in_data), .misr_reset(misr_reset), .sig(sig),
    .sig_vld(sig_vld), .busy(busy)
  );

  ccx_misr_compactor #(.DATA_W(101), .POLY(101'h15), .WINDOW(124)) dut_big (
    .clk(clk), .rst(rst), .ena(1'b1), .start(big_start), .in_vld(1'b0),
    .in_data(big_data), .misr_reset(big_misr_reset), .sig(big_sig),
    .sig_vld(big_sig_vld), .busy(big_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a window from IDLE/DONE and land in the first RUN cycle.
  task automatic begin_window();
    start = 1'b1;
    tick();
    chk_eq("mr_in_reset", misr_reset, 1'b1);
    chk_eq("busy_in_reset", busy, 1'b1);
    chk_eq("vld_in_reset", sig_vld, 1'b0);
    start = 1'b0;
    tick();
    chk_eq("mr_one_cycle", misr_reset, 1'b0);
    chk_eq("sig_cleared", sig, 8'h00);
  endtask

  initial begin
    logic found;
    int   gap;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1; ena = 1'b1; start = 1'b0; in_vld = 1'b0; in_data = 8'h00;
    big_start = 1'b0; big_data = '0;

    // 1: reset values
    tick(); tick(); tick();
    rst = 1'b0;
    chk_eq("rst_sig", sig, 8'h00);
    chk_eq("rst_vld", sig_vld, 1'b0);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_mr", misr_reset, 1'b0);
    tick(); tick();
    chk_eq("idle_busy", busy, 1'b0);
    chk_eq("idle_mr", misr_reset, 1'b0);

    // 2: single low bit
    begin_window();
    in_vld = 1'b1; in_data = 8'h01;
    tick(); chk_eq("s2_c1", sig, 8'h01);
    in_vld = 1'b0; in_data = 8'hAA;
    tick(); chk_eq("s2_c2", sig, 8'h02);
    tick(); chk_eq("s2_c3", sig, 8'h04);
    chk_eq("s2_vld_early", sig_vld, 1'b0);
    tick(); chk_eq("s2_final", sig, 8'h08);
    chk_eq("s2_vld", sig_vld, 1'b1);
    chk_eq("s2_busy", busy, 1'b0);
    tick(); chk_eq("s2_hold", sig, 8'h08);
    chk_eq("s2_vld_hold", sig_vld, 1'b1);

    // 3: feedback path
    begin_window();
    chk_eq("s3_vld_clr", sig_vld, 1'b0);
    in_vld = 1'b1; in_data = 8'h80;
    tick(); chk_eq("s3_c1", sig, 8'h80);
    in_vld = 1'b0;
    tick(); chk_eq("s3_c2", sig, 8'h1D);
    tick(); chk_eq("s3_c3", sig, 8'h3A);
    tick(); chk_eq("s3_final", sig, 8'h74);
    chk_eq("s3_vld", sig_vld, 1'b1);

    // 4: ena gaps
    begin_window();
    in_vld = 1'b1; in_data = 8'h01;
    tick(); chk_eq("s4_c1", sig, 8'h01);
    in_vld = 1'b0;
    tick(); chk_eq("s4_c2", sig, 8'h02);
    ena = 1'b0; in_vld = 1'b1; in_data = 8'hFF;
    tick(); chk_eq("s4_gap1", sig, 8'h02);
    tick(); chk_eq("s4_gap2", sig, 8'h02);
    chk_eq("s4_gap_busy", busy, 1'b1);
    ena = 1'b1; in_vld = 1'b0;
    tick(); chk_eq("s4_c3", sig, 8'h04);
    chk_eq("s4_vld_early", sig_vld, 1'b0);
    tick(); chk_eq("s4_final", sig, 8'h08);
    chk_eq("s4_vld", sig_vld, 1'b1);

    // 5a: start ignored during RUN
    begin_window();
    start = 1'b1; in_vld = 1'b1; in_data = 8'h01;
    tick(); chk_eq("s5_c1", sig, 8'h01);
    chk_eq("s5_no_mr1", misr_reset, 1'b0);
    in_vld = 1'b0;
    tick(); chk_eq("s5_c2", sig, 8'h02);
    chk_eq("s5_no_mr2", misr_reset, 1'b0);
    start = 1'b0;
    tick(); tick();
    chk_eq("s5_final", sig, 8'h08);
    chk_eq("s5_vld", sig_vld, 1'b1);

    // 5b: reset mid-window
    begin_window();
    in_vld = 1'b1; in_data = 8'h01;
    tick(); chk_eq("s5b_c1", sig, 8'h01);
    in_vld = 1'b0; rst = 1'b1; start = 1'b1;
    tick();
    chk_eq("s5b_sig", sig, 8'h00);
    chk_eq("s5b_busy", busy, 1'b0);
    chk_eq("s5b_mr", misr_reset, 1'b0);
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_eq("s5b_no_vld", sig_vld, 1'b0);
      chk_eq("s5b_idle", busy, 1'b0);
    end

    // 6: back-to-back windows with start held
    start = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      chk_eq("s6_mr", misr_reset, (i % 6) == 0);
      chk_eq("s6_vld", sig_vld, (i % 6) == 5);
      chk_eq("s6_busy", busy, (i % 6) <= 4);
      tick();
    end
    start = 1'b0;

    // 6b: full-size spacing misr_reset -> sig_vld
    big_start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (big_misr_reset) found = 1'b1;
    end
    chk_eq("big_mr_seen", found, 1'b1);
    big_start = 1'b0;
    gap = 0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      gap = gap + 1;
      if (big_sig_vld) found = 1'b1;
    end
    chk_eq("big_vld_seen", found, 1'b1);
    chk_eq("big_spacing", gap, 125);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
